// File: rtl/img_pkg.sv
// Shared image geometry and fetch FSM encoding, used by image_fetch and the preprocess block.
package img_pkg;

    localparam int unsigned IMG_COLS   = 540;
    localparam int unsigned IMG_ROWS   = 540;
    localparam int unsigned PRIME_ROWS = 3;
    localparam int unsigned ADDR_W     = 19;

    typedef enum logic [2:0] {
        StIdle,
        StPrime,
        StWait,
        StRow,
        StDrain
    } fetch_state_e;

endpackage

// File: rtl/fetch_addr_gen.sv
// Column, burst-row and linear address counters for image_fetch.
// Flags the last read of the current PRIME or ROW burst.
module fetch_addr_gen
    import img_pkg::*;
#(
    parameter int unsigned COLS = 540,
    parameter int unsigned AW   = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          next_row,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic          col_last,
    output logic          burst_last
);

    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic [COL_W-1:0] col;
    logic [1:0]       brow;
    logic             prime;

    assign col_last   = (col == COL_W'(COLS - 1));
    assign burst_last = col_last && (!prime || (brow == 2'(PRIME_ROWS - 1)));

    // The address is left on the last read of a burst and bumped when the next row starts,
    // so it never steps past the final pixel of the image.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr  <= '0;
            col   <= '0;
            brow  <= '0;
            prime <= 1'b0;
        end else if (clear) begin
            addr  <= '0;
            col   <= '0;
            brow  <= '0;
            prime <= 1'b1;
        end else if (next_row) begin
            addr  <= addr + AW'(1);
            col   <= '0;
            brow  <= '0;
            prime <= 1'b0;
        end else if (step) begin
            addr <= addr + AW'(1);
            if (col_last) begin
                col  <= '0;
                brow <= brow + 2'd1;
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/image_fetch.sv
// Streams image rows from memory: a 3-row prime burst, then one row per request.
// Holds the burst FSM and the 2-stage valid/data pipeline.
module image_fetch
    import img_pkg::fetch_state_e, img_pkg::StIdle, img_pkg::StPrime, img_pkg::StWait,
           img_pkg::StRow, img_pkg::StDrain;
#(
    parameter int unsigned IMG_COLS = img_pkg::IMG_COLS,
    parameter int unsigned IMG_ROWS = img_pkg::IMG_ROWS,
    parameter int unsigned ADDR_W   = img_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              row_req_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_data_i,
    output logic [7:0]        data_o,
    output logic              fetch_en_o,
    output logic              row_done_o,
    output logic              img_done_o,
    output logic              busy_o,
    output logic [9:0]        cnt_row_o
);

    fetch_state_e      state;
    logic              mem_rd;
    logic              drain_2nd;
    logic              img_done;
    logic              rd_d1;
    logic              last_d1;
    logic              fetch_en;
    logic              row_done;
    logic [7:0]        data;
    logic [9:0]        cnt_row;
    logic              clear;
    logic              next_row;
    logic              step;
    logic              col_last;
    logic              burst_last;
    logic [ADDR_W-1:0] addr;

    assign clear    = (state == StIdle) && start_i;
    assign next_row = (state == StWait) && row_req_i;
    assign step     = ((state == StPrime) || (state == StRow)) && !burst_last;

    fetch_addr_gen #(
        .COLS (IMG_COLS),
        .AW   (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .next_row   (next_row),
        .step       (step),
        .addr       (addr),
        .col_last   (col_last),
        .burst_last (burst_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            mem_rd    <= 1'b0;
            drain_2nd <= 1'b0;
            img_done  <= 1'b0;
        end else begin
            img_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start_i) begin
                        state  <= StPrime;
                        mem_rd <= 1'b1;
                    end
                end
                StPrime, StRow: begin
                    if (burst_last) begin
                        state     <= StDrain;
                        mem_rd    <= 1'b0;
                        drain_2nd <= 1'b0;
                    end
                end
                StWait: begin
                    if (row_req_i) begin
                        state  <= StRow;
                        mem_rd <= 1'b1;
                    end
                end
                StDrain: begin
                    drain_2nd <= 1'b1;
                    // The last row_done has already bumped cnt_row by the second drain cycle.
                    if (drain_2nd) begin
                        drain_2nd <= 1'b0;
                        if (cnt_row == 10'(IMG_ROWS)) begin
                            state    <= StIdle;
                            img_done <= 1'b1;
                        end else begin
                            state <= StWait;
                        end
                    end
                end
                default: begin
                    state  <= StIdle;
                    mem_rd <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_d1    <= 1'b0;
            last_d1  <= 1'b0;
            fetch_en <= 1'b0;
            row_done <= 1'b0;
            data     <= 8'd0;
            cnt_row  <= 10'd0;
        end else begin
            rd_d1    <= mem_rd;
            last_d1  <= mem_rd && col_last;
            fetch_en <= rd_d1;
            row_done <= last_d1;
            data     <= rd_d1 ? mem_data_i : 8'd0;
            if (clear) begin
                cnt_row <= 10'd0;
            end else if (last_d1) begin
                cnt_row <= cnt_row + 10'd1;
            end
        end
    end

    assign mem_rd_o   = mem_rd;
    assign mem_addr_o = addr;
    assign data_o     = data;
    assign fetch_en_o = fetch_en;
    assign row_done_o = row_done;
    assign img_done_o = img_done;
    assign busy_o     = (state != StIdle);
    assign cnt_row_o  = cnt_row;

endmodule

// File: tb/tb_image_fetch.sv
// Directed bench for image_fetch on a 540x5 image; memory returns the low address byte.
module tb_image_fetch;
    import img_pkg::*;

    localparam int unsigned COLS = 540;
    localparam int unsigned ROWS = 5;
    localparam int unsigned AW   = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          row_req_i;
    logic          mem_rd_o;
    logic [AW-1:0] mem_addr_o;
    logic [7:0]    mem_data_i;
    logic [7:0]    data_o;
    logic          fetch_en_o;
    logic          row_done_o;
    logic          img_done_o;
    logic          busy_o;
    logic [9:0]    cnt_row_o;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    // mem[a] = a mod 256, valid one cycle after the strobe; junk otherwise.
    always @(posedge clk) mem_data_i <= mem_rd_o ? mem_addr_o[7:0] : 8'hA5;

    image_fetch #(
        .IMG_COLS (COLS),
        .IMG_ROWS (ROWS),
        .ADDR_W   (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .row_req_i  (row_req_i),
        .mem_rd_o   (mem_rd_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_i (mem_data_i),
        .data_o     (data_o),
        .fetch_en_o (fetch_en_o),
        .row_done_o (row_done_o),
        .img_done_o (img_done_o),
        .busy_o     (busy_o),
        .cnt_row_o  (cnt_row_o)
    );

    task automatic test_reset();
        logic [AW+14:0] outs;
        rst = 1'b1;
        start_i = 1'b0;
        row_req_i = 1'b0;
        @(negedge clk);
        outs = {mem_rd_o, mem_addr_o, data_o, fetch_en_o, row_done_o, img_done_o, busy_o,
                cnt_row_o};
        vectors++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want all zero", outs);
        end
        vectors++;
        if (dut.state !== StIdle) begin
            errors++;
            $display("FAIL reset_state: got %0d, want IDLE", int'(dut.state));
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_prime();
        int n = 0, pulses = 0, gaps = 0, bad_data = 0, bad_rd = 0, bad_zero = 0, extra = 0;
        bit ended = 1'b0;
        logic exp_rd;
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
        vectors++;
        if (mem_rd_o !== 1'b1 || mem_addr_o !== '0) begin
            errors++;
            $display("FAIL prime_first_read: rd=%b addr=%0d, want rd=1 addr=0", mem_rd_o,
                     mem_addr_o);
        end
        @(negedge clk);
        vectors++;
        if (fetch_en_o !== 1'b0) begin
            errors++;
            $display("FAIL prime_latency_early: fetch_en=%b at start+2, want 0", fetch_en_o);
        end
        @(negedge clk);
        vectors++;
        if (fetch_en_o !== 1'b1 || data_o !== 8'd0) begin
            errors++;
            $display("FAIL prime_first_pixel: fetch_en=%b data=%0d, want 1 and 0", fetch_en_o,
                     data_o);
        end
        // Pulses of row_req_i and start_i during PRIME must be ignored.
        for (int cyc = 0; cyc < 2500 && dut.state !== StWait; cyc++) begin
            exp_rd = 1'b0;
            if (fetch_en_o === 1'b1) begin
                if (ended) gaps++;
                if (data_o !== 8'(n)) bad_data++;
                exp_rd = ((n % COLS) == COLS - 1);
                n++;
            end else begin
                if (n > 0) ended = 1'b1;
                if (data_o !== 8'd0) bad_zero++;
            end
            if (row_done_o !== exp_rd) bad_rd++;
            if (row_done_o === 1'b1) pulses++;
            row_req_i = (n == 100);
            start_i   = (n == 200);
            @(negedge clk);
        end
        row_req_i = 1'b0;
        start_i = 1'b0;
        vectors++;
        if (n != 1620) begin
            errors++;
            $display("FAIL prime_valid_count: got %0d, want 1620", n);
        end
        vectors++;
        if (bad_data != 0 || gaps != 0 || bad_zero != 0) begin
            errors++;
            $display("FAIL prime_data_seq: bad_data=%0d gaps=%0d nonzero_idle=%0d, want 0 0 0",
                     bad_data, gaps, bad_zero);
        end
        vectors++;
        if (pulses != 3 || bad_rd != 0) begin
            errors++;
            $display("FAIL prime_row_done: pulses=%0d misplaced=%0d, want 3 and 0", pulses,
                     bad_rd);
        end
        vectors++;
        if (cnt_row_o !== 10'd3 || mem_addr_o !== AW'(1619) || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL prime_end_state: cnt_row=%0d addr=%0d busy=%b, want 3 1619 1",
                     cnt_row_o, mem_addr_o, busy_o);
        end
        for (int i = 0; i < 10; i++) begin
            if (mem_rd_o !== 1'b0) extra++;
            @(negedge clk);
        end
        vectors++;
        if (extra != 0 || dut.state !== StWait) begin
            errors++;
            $display("FAIL prime_wait_hold: extra_reads=%0d state=%0d, want 0 and WAIT", extra,
                     int'(dut.state));
        end
    endtask

    task automatic test_row();
        int n = 0, pulses = 0, gaps = 0, bad_data = 0, extra = 0;
        bit ended = 1'b0;
        @(negedge clk) row_req_i = 1'b1;
        @(negedge clk) row_req_i = 1'b0;
        vectors++;
        if (mem_rd_o !== 1'b1 || mem_addr_o !== AW'(1620)) begin
            errors++;
            $display("FAIL row_first_read: rd=%b addr=%0d, want rd=1 addr=1620", mem_rd_o,
                     mem_addr_o);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (fetch_en_o !== 1'b1 || data_o !== 8'd84) begin
            errors++;
            $display("FAIL row_first_pixel: fetch_en=%b data=%0d, want 1 and 84", fetch_en_o,
                     data_o);
        end
        // row_req_i/start_i mid-ROW, and row_req_i on the DRAIN->WAIT edge, are all dropped.
        for (int cyc = 0; cyc < 1000 && dut.state !== StWait; cyc++) begin
            if (fetch_en_o === 1'b1) begin
                if (ended) gaps++;
                if (data_o !== 8'(1620 + n)) bad_data++;
                n++;
            end else if (n > 0) begin
                ended = 1'b1;
            end
            if (row_done_o === 1'b1) pulses++;
            row_req_i = (n == 50) || (row_done_o === 1'b1);
            start_i   = (n == 60);
            @(negedge clk);
        end
        row_req_i = 1'b0;
        start_i = 1'b0;
        vectors++;
        if (n != 540 || gaps != 0 || bad_data != 0) begin
            errors++;
            $display("FAIL row_burst: count=%0d gaps=%0d bad_data=%0d, want 540 0 0", n, gaps,
                     bad_data);
        end
        vectors++;
        if (pulses != 1 || cnt_row_o !== 10'd4) begin
            errors++;
            $display("FAIL row_count: pulses=%0d cnt_row=%0d, want 1 and 4", pulses, cnt_row_o);
        end
        for (int i = 0; i < 10; i++) begin
            if (mem_rd_o !== 1'b0) extra++;
            @(negedge clk);
        end
        vectors++;
        if (extra != 0 || dut.state !== StWait || mem_addr_o !== AW'(2159)) begin
            errors++;
            $display("FAIL row_ignored_reqs: extra_reads=%0d state=%0d addr=%0d, want 0 WAIT 2159",
                     extra, int'(dut.state), mem_addr_o);
        end
    endtask

    task automatic test_last_row();
        int n = 0, bad_data = 0, done_cnt = 0, done_cyc = -1, last_fe = -1;
        logic [AW-1:0] last_addr = '0;
        @(negedge clk) row_req_i = 1'b1;
        @(negedge clk) row_req_i = 1'b0;
        for (int cyc = 0; cyc < 620; cyc++) begin
            if (mem_rd_o === 1'b1) last_addr = mem_addr_o;
            if (fetch_en_o === 1'b1) begin
                if (data_o !== 8'(2160 + n)) bad_data++;
                n++;
                last_fe = cyc;
            end
            if (img_done_o === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            @(negedge clk);
        end
        vectors++;
        if (n != 540 || bad_data != 0) begin
            errors++;
            $display("FAIL last_row_burst: count=%0d bad_data=%0d, want 540 and 0", n, bad_data);
        end
        vectors++;
        if (done_cnt != 1 || done_cyc != last_fe + 1) begin
            errors++;
            $display("FAIL img_done_pulse: pulses=%0d at %0d, want 1 at %0d", done_cnt, done_cyc,
                     last_fe + 1);
        end
        vectors++;
        if (last_addr !== AW'(2699)) begin
            errors++;
            $display("FAIL last_address: got %0d, want 2699", last_addr);
        end
        vectors++;
        if (busy_o !== 1'b0 || cnt_row_o !== 10'd5) begin
            errors++;
            $display("FAIL image_end_state: busy=%b cnt_row=%0d, want 0 and 5", busy_o,
                     cnt_row_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n = 0, stray = 0;
        logic [AW+14:0] outs;
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
        for (int cyc = 0; cyc < 1000 && n < 700; cyc++) begin
            if (fetch_en_o === 1'b1) n++;
            @(negedge clk);
        end
        vectors++;
        if (n != 700 || data_o !== 8'(700 % 256)) begin
            errors++;
            $display("FAIL mid_burst_reach: count=%0d data=%0d, want 700 and %0d", n, data_o,
                     700 % 256);
        end
        rst = 1'b1;
        @(negedge clk);
        outs = {mem_rd_o, mem_addr_o, data_o, fetch_en_o, row_done_o, img_done_o, busy_o,
                cnt_row_o};
        vectors++;
        if (outs !== '0 || dut.state !== StIdle) begin
            errors++;
            $display("FAIL mid_burst_reset: outputs=%h state=%0d, want zero and IDLE", outs,
                     int'(dut.state));
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (fetch_en_o !== 1'b0 || mem_rd_o !== 1'b0) stray++;
            @(negedge clk);
        end
        vectors++;
        if (stray != 0) begin
            errors++;
            $display("FAIL reset_flush: %0d cycles with stray strobes, want 0", stray);
        end
        start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
        vectors++;
        if (mem_rd_o !== 1'b1 || mem_addr_o !== '0 || cnt_row_o !== 10'd0) begin
            errors++;
            $display("FAIL restart_read: rd=%b addr=%0d cnt_row=%0d, want 1 0 0", mem_rd_o,
                     mem_addr_o, cnt_row_o);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (fetch_en_o !== 1'b1 || data_o !== 8'd0) begin
            errors++;
            $display("FAIL restart_pixel: fetch_en=%b data=%0d, want 1 and 0", fetch_en_o,
                     data_o);
        end
    endtask

    initial begin
        test_reset();
        test_prime();
        test_row();
        test_last_row();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
